udma_sdio_cmd_seq: RTL and testbench

SDIO command sequencer in the sys_clk_i domain of the uDMA SDIO peripheral. Queues command descriptors from the register interface and loads each one into the SDIO transceiver's command/data configuration. Issues the start pulse, waits for end-of-transfer or error, retries failed or timed-out commands, and returns one completion record per descriptor. Sits between the register interface and the start/eot/err/status synchronisers.

---
 rtl/udma_sdio_cmd_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_udma_sdio_cmd_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_sdio_cmd_seq.sv
// SDIO command sequencer: queues command descriptors, issues them to the transceiver,
// retries failed or timed-out attempts, and returns one completion record per descriptor.
module udma_sdio_cmd_seq #(
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_RETRY   = 2,
    parameter int RETRY_GAP   = 8,
    parameter int TIMEOUT_W   = 20
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    input  logic [5:0]           desc_op_i,
    input  logic [31:0]          desc_arg_i,
    input  logic [2:0]           desc_rsp_type_i,
    input  logic                 desc_data_en_i,
    input  logic                 desc_data_rwn_i,
    input  logic [3:0]           desc_tag_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    input  logic                 abort_i,
    output logic [5:0]           cmd_op_o,
    output logic [31:0]          cmd_arg_o,
    output logic [2:0]           cmd_rsp_type_o,
    output logic                 data_en_o,
    output logic                 data_rwn_o,
    output logic                 start_o,
    input  logic                 eot_i,
    input  logic                 err_i,
    input  logic [15:0]          status_i,
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic [3:0]           done_tag_o,
    output logic                 done_ok_o,
    output logic                 done_abort_o,
    output logic [2:0]           done_retries_o,
    output logic [15:0]          done_status_o,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(QUEUE_DEPTH);
    localparam logic [2:0]       MAX_RETRY_C = 3'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LOAD_C  = GAP_W'(RETRY_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GAP,
        REPORT
    } state_e;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] arg;
        logic [2:0]  rspType;
        logic        dataEn;
        logic        dataRwn;
        logic [3:0]  tag;
    } desc_t;

    desc_t               queueMem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    state_e              state_q, state_d;
    desc_t               cmd_q, cmd_d;
    logic [2:0]          retryCnt_q, retryCnt_d;
    logic [GAP_W-1:0]    gapCnt_q, gapCnt_d;
    logic [TIMEOUT_W-1:0] tmoCnt_q, tmoCnt_d;
    logic                doneOk_q, doneOk_d;
    logic                doneAbort_q, doneAbort_d;
    logic [15:0]         doneStatus_q, doneStatus_d;

    logic                push;
    logic                pop;
    logic [TIMEOUT_W:0]  tmoNext;
    logic                tmoHit;
    desc_t               pushDesc;

    assign desc_ready_o = (count_q < DEPTH_C) && !abort_i;
    assign push         = desc_valid_i && desc_ready_o;
    assign pop          = (state_q == IDLE) && (count_q != '0) && !abort_i;

    assign pushDesc = '{op: desc_op_i, arg: desc_arg_i, rspType: desc_rsp_type_i,
                        dataEn: desc_data_en_i, dataRwn: desc_data_rwn_i, tag: desc_tag_i};

    // tmoNext is the count including the current WAIT cycle, so the first WAIT cycle is 1.
    assign tmoNext = {1'b0, tmoCnt_q} + (TIMEOUT_W + 1)'(1);
    assign tmoHit  = (cfg_timeout_i != '0) && (tmoNext == {1'b0, cfg_timeout_i});

    always_ff @(posedge clk_i) begin
        if (push) begin
            queueMem_q[wrPtr_q] <= pushDesc;
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (abort_i) begin
            rdPtr_d = wrPtr_q;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        retryCnt_d   = retryCnt_q;
        gapCnt_d     = gapCnt_q;
        tmoCnt_d     = tmoCnt_q;
        doneOk_d     = doneOk_q;
        doneAbort_d  = doneAbort_q;
        doneStatus_d = doneStatus_q;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    cmd_d      = queueMem_q[rdPtr_q];
                    retryCnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                tmoCnt_d = '0;
                if (abort_i) begin
                    doneOk_d     = 1'b0;
                    doneAbort_d  = 1'b1;
                    doneStatus_d = status_i;
                    state_d      = REPORT;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tmoCnt_d = (&tmoCnt_q) ? tmoCnt_q : tmoNext[TIMEOUT_W-1:0];
                if (abort_i) begin
                    doneOk_d     = 1'b0;
                    doneAbort_d  = 1'b1;
                    doneStatus_d = status_i;
                    state_d      = REPORT;
                end else if (err_i || tmoHit) begin
                    // An error takes precedence over a simultaneous end-of-transfer.
                    if (retryCnt_q < MAX_RETRY_C) begin
                        retryCnt_d = retryCnt_q + 3'd1;
                        gapCnt_d   = GAP_LOAD_C;
                        state_d    = GAP;
                    end else begin
                        doneOk_d     = 1'b0;
                        doneAbort_d  = 1'b0;
                        doneStatus_d = status_i;
                        state_d      = REPORT;
                    end
                end else if (eot_i) begin
                    doneOk_d     = 1'b1;
                    doneAbort_d  = 1'b0;
                    doneStatus_d = status_i;
                    state_d      = REPORT;
                end
            end
            GAP: begin
                if (abort_i) begin
                    doneOk_d     = 1'b0;
                    doneAbort_d  = 1'b1;
                    doneStatus_d = status_i;
                    state_d      = REPORT;
                end else if (gapCnt_q == '0) begin
                    state_d = START;
                end else begin
                    gapCnt_d = gapCnt_q - GAP_W'(1);
                end
            end
            REPORT: begin
                if (done_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            retryCnt_q   <= '0;
            gapCnt_q     <= '0;
            tmoCnt_q     <= '0;
            doneOk_q     <= 1'b0;
            doneAbort_q  <= 1'b0;
            doneStatus_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            retryCnt_q   <= retryCnt_d;
            gapCnt_q     <= gapCnt_d;
            tmoCnt_q     <= tmoCnt_d;
            doneOk_q     <= doneOk_d;
            doneAbort_q  <= doneAbort_d;
            doneStatus_q <= doneStatus_d;
        end
    end

    assign cmd_op_o       = cmd_q.op;
    assign cmd_arg_o      = cmd_q.arg;
    assign cmd_rsp_type_o = cmd_q.rspType;
    assign data_en_o      = cmd_q.dataEn;
    assign data_rwn_o     = cmd_q.dataRwn;
    assign start_o        = (state_q == START);
    assign done_valid_o   = (state_q == REPORT);
    assign done_tag_o     = cmd_q.tag;
    assign done_ok_o      = doneOk_q;
    assign done_abort_o   = doneAbort_q;
    assign done_retries_o = retryCnt_q;
    assign done_status_o  = doneStatus_q;
    assign busy_o         = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_udma_sdio_cmd_seq.sv
// Bench for udma_sdio_cmd_seq: a cycle table for a single command, then hand-written
// sequences for queue fill, retries, timeout, abort, completion back-pressure and reset.
module tb_udma_sdio_cmd_seq;

    localparam int RETRY_GAP = 8;
    localparam int TIMEOUT_W = 20;

    logic                 clk;
    logic                 rstn;
    logic                 descValid;
    logic                 descReady;
    logic [5:0]           descOp;
    logic [31:0]          descArg;
    logic [2:0]           descRspType;
    logic                 descDataEn;
    logic                 descDataRwn;
    logic [3:0]           descTag;
    logic [TIMEOUT_W-1:0] cfgTimeout;
    logic                 abort;
    logic [5:0]           cmdOp;
    logic [31:0]          cmdArg;
    logic [2:0]           cmdRspType;
    logic                 dataEn;
    logic                 dataRwn;
    logic                 start;
    logic                 eot;
    logic                 err;
    logic [15:0]          status;
    logic                 doneValid;
    logic                 doneReady;
    logic [3:0]           doneTag;
    logic                 doneOk;
    logic                 doneAbort;
    logic [2:0]           doneRetries;
    logic [15:0]          doneStatus;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    udma_sdio_cmd_seq #(
        .QUEUE_DEPTH(4),
        .MAX_RETRY  (2),
        .RETRY_GAP  (RETRY_GAP),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .desc_valid_i   (descValid),
        .desc_ready_o   (descReady),
        .desc_op_i      (descOp),
        .desc_arg_i     (descArg),
        .desc_rsp_type_i(descRspType),
        .desc_data_en_i (descDataEn),
        .desc_data_rwn_i(descDataRwn),
        .desc_tag_i     (descTag),
        .cfg_timeout_i  (cfgTimeout),
        .abort_i        (abort),
        .cmd_op_o       (cmdOp),
        .cmd_arg_o      (cmdArg),
        .cmd_rsp_type_o (cmdRspType),
        .data_en_o      (dataEn),
        .data_rwn_o     (dataRwn),
        .start_o        (start),
        .eot_i          (eot),
        .err_i          (err),
        .status_i       (status),
        .done_valid_o   (doneValid),
        .done_ready_i   (doneReady),
        .done_tag_o     (doneTag),
        .done_ok_o      (doneOk),
        .done_abort_o   (doneAbort),
        .done_retries_o (doneRetries),
        .done_status_o  (doneStatus),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [31:0] arg;
        logic [3:0]  tag;
        logic        eot;
        logic        err;
        logic        dready;
        logic [15:0] status;
        int          reps;
        logic        expReady;
        logic        expStart;
        logic        expDv;
        logic        expBusy;
        logic [5:0]  expOp;
        logic [3:0]  expTag;
        logic        expOk;
        logic [15:0] expStatus;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mkVec(input logic valid, input logic [5:0] op, input logic [31:0] arg,
                                   input logic [3:0] tag, input logic eotIn, input logic errIn,
                                   input logic dready, input logic [15:0] st, input int reps,
                                   input logic eReady, input logic eStart, input logic eDv,
                                   input logic eBusy, input logic [5:0] eOp, input logic [3:0] eTag,
                                   input logic eOk, input logic [15:0] eStatus);
        vec_t v;
        v.valid = valid; v.op = op; v.arg = arg; v.tag = tag;
        v.eot = eotIn; v.err = errIn; v.dready = dready; v.status = st; v.reps = reps;
        v.expReady = eReady; v.expStart = eStart; v.expDv = eDv; v.expBusy = eBusy;
        v.expOp = eOp; v.expTag = eTag; v.expOk = eOk; v.expStatus = eStatus;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        descValid = v.valid;
        descOp    = v.op;
        descArg   = v.arg;
        descTag   = v.tag;
        eot       = v.eot;
        err       = v.err;
        doneReady = v.dready;
        status    = v.status;
    endtask

    task automatic pushDesc(input logic [5:0] op, input logic [3:0] tag);
        @(negedge clk);
        descValid = 1'b1;
        descOp    = op;
        descArg   = {16'hA500, 10'h0, op};
        descTag   = tag;
        #1 checkOutput($sformatf("push tag%0d ready", tag), descReady, 1);
        @(negedge clk);
        descValid = 1'b0;
    endtask

    task automatic waitStart(input string name, input int budget, output int waited);
        waited = 0;
        while (start !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, " start seen"}, start, 1);
    endtask

    task automatic pulseEvent(input logic isErr, input logic [15:0] st);
        @(negedge clk);
        eot    = !isErr;
        err    = isErr;
        status = st;
        @(negedge clk);
        eot    = 1'b0;
        err    = 1'b0;
        status = 16'h5555;
    endtask

    task automatic acceptDone(input string name, input logic [3:0] tag, input logic ok,
                              input logic ab, input logic [2:0] retries, input logic [15:0] st);
        checkOutput({name, " done_valid"}, doneValid, 1);
        checkOutput({name, " tag"}, doneTag, tag);
        checkOutput({name, " ok"}, doneOk, ok);
        checkOutput({name, " abort"}, doneAbort, ab);
        checkOutput({name, " retries"}, doneRetries, retries);
        checkOutput({name, " status"}, doneStatus, st);
        doneReady = 1'b1;
        @(negedge clk);
        doneReady = 1'b0;
        checkOutput({name, " done_valid cleared"}, doneValid, 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int waited;
        int starts;

        rstn = 1'b0;
        descValid = 1'b0; descOp = '0; descArg = '0; descRspType = 3'd1;
        descDataEn = 1'b1; descDataRwn = 1'b1; descTag = '0;
        cfgTimeout = '0; abort = 1'b0; eot = 1'b0; err = 1'b0;
        status = '0; doneReady = 1'b0;

        // Single command op=17 arg=0x200 tag=3, eot ten cycles after start.
        vecs[0] = mkVec(0, 6'd0,  32'h0,   4'd0, 0, 0, 0, 16'h0000, 2, 1, 0, 0, 0, 6'd0,  4'd0, 0, 16'h0);
        vecs[1] = mkVec(1, 6'd17, 32'h200, 4'd3, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 6'd0,  4'd0, 0, 16'h0);
        vecs[2] = mkVec(0, 6'd0,  32'h0,   4'd0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 1, 6'd0,  4'd0, 0, 16'h0);
        vecs[3] = mkVec(0, 6'd0,  32'h0,   4'd0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 1, 6'd17, 4'd0, 0, 16'h0);
        vecs[4] = mkVec(0, 6'd0,  32'h0,   4'd0, 0, 0, 0, 16'h0000, 9, 1, 0, 0, 1, 6'd17, 4'd0, 0, 16'h0);
        vecs[5] = mkVec(0, 6'd0,  32'h0,   4'd0, 1, 0, 0, 16'hBEEF, 1, 1, 0, 0, 1, 6'd17, 4'd0, 0, 16'h0);
        vecs[6] = mkVec(0, 6'd0,  32'h0,   4'd0, 0, 0, 0, 16'h1111, 3, 1, 0, 1, 1, 6'd17, 4'd3, 1, 16'hBEEF);
        vecs[7] = mkVec(0, 6'd0,  32'h0,   4'd0, 0, 0, 1, 16'h1111, 1, 1, 0, 1, 1, 6'd17, 4'd3, 1, 16'hBEEF);
        vecs[8] = mkVec(0, 6'd0,  32'h0,   4'd0, 0, 0, 0, 16'h0000, 2, 1, 0, 0, 0, 6'd17, 4'd0, 0, 16'h0);

        repeat (3) @(negedge clk);
        checkOutput("reset desc_ready", descReady, 1);
        checkOutput("reset start", start, 0);
        checkOutput("reset done_valid", doneValid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset cmd_op", cmdOp, 0);
        checkOutput("reset cmd_arg", cmdArg, 0);
        checkOutput("reset done_status", doneStatus, 0);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                @(negedge clk);
                applyStimulus(vecs[i]);
                #1;
                checkOutput($sformatf("vec%0d.%0d ready", i, r), descReady, vecs[i].expReady);
                checkOutput($sformatf("vec%0d.%0d start", i, r), start, vecs[i].expStart);
                checkOutput($sformatf("vec%0d.%0d done_valid", i, r), doneValid, vecs[i].expDv);
                checkOutput($sformatf("vec%0d.%0d busy", i, r), busy, vecs[i].expBusy);
                checkOutput($sformatf("vec%0d.%0d cmd_op", i, r), cmdOp, vecs[i].expOp);
                if (vecs[i].expDv) begin
                    checkOutput($sformatf("vec%0d.%0d tag", i, r), doneTag, vecs[i].expTag);
                    checkOutput($sformatf("vec%0d.%0d ok", i, r), doneOk, vecs[i].expOk);
                    checkOutput($sformatf("vec%0d.%0d retries", i, r), doneRetries, 0);
                    checkOutput($sformatf("vec%0d.%0d status", i, r), doneStatus, vecs[i].expStatus);
                end
            end
        end

        // Queue fill behind a busy transceiver, then in-order drain.
        pushDesc(6'd2, 4'd15);
        waitStart("blocker", 10, waited);
        for (int t = 0; t < 4; t++) begin
            pushDesc(6'(20 + t), 4'(t));
        end
        @(negedge clk);
        descValid = 1'b1;
        descTag   = 4'd4;
        #1 checkOutput("fifth push ready", descReady, 0);
        @(negedge clk);
        descValid = 1'b0;
        pulseEvent(1'b0, 16'h0F0F);
        acceptDone("blocker", 4'd15, 1, 0, 3'd0, 16'h0F0F);
        for (int t = 0; t < 4; t++) begin
            waitStart($sformatf("drain%0d", t), 10, waited);
            checkOutput($sformatf("drain%0d pop latency", t), waited, 1);
            checkOutput($sformatf("drain%0d cmd_op", t), cmdOp, 20 + t);
            checkOutput($sformatf("drain%0d cmd_arg", t), cmdArg, {16'hA500, 10'h0, 6'(20 + t)});
            pulseEvent(1'b0, 16'(16'h0100 + t));
            acceptDone($sformatf("drain%0d", t), 4'(t), 1, 0, 3'd0, 16'(16'h0100 + t));
        end
        checkOutput("drain idle busy", busy, 0);

        // Error on every attempt: two reissues, each RETRY_GAP cycles after the failure.
        pushDesc(6'd5, 4'd7);
        waitStart("retry a0", 10, waited);
        pulseEvent(1'b1, 16'hE0E0);
        checkOutput("retry gap start low", start, 0);
        waitStart("retry a1", 50, waited);
        checkOutput("retry a1 gap", waited, RETRY_GAP);
        checkOutput("retry a1 cmd_op", cmdOp, 5);
        pulseEvent(1'b1, 16'hE1E1);
        waitStart("retry a2", 50, waited);
        checkOutput("retry a2 gap", waited, RETRY_GAP);
        pulseEvent(1'b1, 16'hE2E2);
        acceptDone("retry", 4'd7, 0, 0, 3'd2, 16'hE2E2);

        // Timeout on the 50th WAIT cycle, success on the retry.
        cfgTimeout = TIMEOUT_W'(50);
        pushDesc(6'd9, 4'd6);
        waitStart("tmo a0", 10, waited);
        @(negedge clk);
        waitStart("tmo a1", 200, waited);
        checkOutput("tmo reissue delay", waited, 50 + RETRY_GAP);
        pulseEvent(1'b0, 16'h6060);
        acceptDone("tmo", 4'd6, 1, 0, 3'd1, 16'h6060);
        cfgTimeout = '0;

        // Abort during WAIT with two descriptors queued.
        pushDesc(6'd3, 4'd9);
        waitStart("abort", 10, waited);
        pushDesc(6'd10, 4'd10);
        pushDesc(6'd11, 4'd11);
        @(negedge clk);
        abort  = 1'b1;
        status = 16'h0AB0;
        #1 checkOutput("abort desc_ready", descReady, 0);
        @(negedge clk);
        abort  = 1'b0;
        status = 16'h0000;
        pulseEvent(1'b0, 16'h7777);
        acceptDone("abort", 4'd9, 0, 1, 3'd0, 16'h0AB0);
        checkOutput("abort queue flushed", busy, 0);
        starts = 0;
        eot = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            eot = 1'b0;
            if (start === 1'b1) starts++;
        end
        checkOutput("abort no further start", starts, 0);
        checkOutput("abort late eot ignored", doneValid, 0);

        // Completion held for 20 cycles while another descriptor is pushed.
        pushDesc(6'd12, 4'd4);
        waitStart("hold", 10, waited);
        pulseEvent(1'b0, 16'h4444);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                descValid = 1'b1;
                descOp    = 6'd13;
                descTag   = 4'd5;
                #1 checkOutput("hold push ready", descReady, 1);
            end
            @(negedge clk);
            descValid = 1'b0;
            checkOutput($sformatf("hold%0d done_valid", c), doneValid, 1);
            checkOutput($sformatf("hold%0d tag", c), doneTag, 4);
            checkOutput($sformatf("hold%0d status", c), doneStatus, 16'h4444);
            checkOutput($sformatf("hold%0d start", c), start, 0);
        end
        acceptDone("hold", 4'd4, 1, 0, 3'd0, 16'h4444);
        checkOutput("b2b start before pop", start, 0);
        @(negedge clk);
        checkOutput("b2b start", start, 1);
        checkOutput("b2b cmd_op", cmdOp, 13);
        pulseEvent(1'b0, 16'h5A5A);
        acceptDone("b2b", 4'd5, 1, 0, 3'd0, 16'h5A5A);

        // Asynchronous reset while start_o is high.
        pushDesc(6'd1, 4'd1);
        waitStart("reset mid", 10, waited);
        #1 rstn = 1'b0;
        #1;
        checkOutput("async reset start", start, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset ready", descReady, 1);
        checkOutput("async reset cmd_op", cmdOp, 0);
        @(negedge clk);
        rstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
